// File: rtl/ddr_rd_arbiter_pkg.sv
// Shared definitions for the DDR read arbiter and its neighbours (ins_cache, DDR interface).
// Holds state encodings, grant bit positions, default widths and the burst-length clamp.
package ddr_rd_arbiter_pkg;

  localparam int unsigned DEF_DDR_ADDR_WIDTH = 28;
  localparam int unsigned DEF_ISA_WIDTH      = 30;
  localparam int unsigned LEN_WIDTH          = 10;

  localparam int unsigned GNT_ISA = 0;
  localparam int unsigned GNT_DAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len,
                                                     input logic [LEN_WIDTH-1:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/ddr_rd_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a contested pick goes to the
// side not served last. The pointer favours ISA out of reset.
module rr_arb2
  import ddr_rd_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served_isa,
  output logic [1:0] pick
);

  logic prefer_dat;

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = '0;
      pick[prefer_dat ? GNT_DAT : GNT_ISA] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prefer_dat <= 1'b0;
    end else if (update) begin
      prefer_dat <= served_isa;
    end
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Shares the single DDR burst-read port between the ISA refill and the data loader:
// one burst at a time, beats routed to the granted side with a saturating beat count.
module ddr_rd_arbiter
  import ddr_rd_arbiter_pkg::*;
#(
  parameter int unsigned DDR_ADDR_WIDTH = DEF_DDR_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ISA_WIDTH      = DEF_ISA_WIDTH,
  parameter int unsigned MAX_BURST      = 128
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      isa_rd_req,
  input  logic [DDR_ADDR_WIDTH-1:0] isa_rd_addr,
  input  logic [LEN_WIDTH-1:0]      isa_rd_len,
  output logic [ISA_WIDTH-1:0]      isa_rd_data,
  output logic                      isa_rd_valid,
  output logic [LEN_WIDTH-1:0]      isa_rd_cnt,
  output logic                      isa_rd_done,
  input  logic                      dat_rd_req,
  input  logic [DDR_ADDR_WIDTH-1:0] dat_rd_addr,
  input  logic [LEN_WIDTH-1:0]      dat_rd_len,
  output logic [DATA_WIDTH-1:0]     dat_rd_data,
  output logic                      dat_rd_valid,
  output logic [LEN_WIDTH-1:0]      dat_rd_cnt,
  output logic                      dat_rd_done,
  output logic                      ddr_rd_req,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
  output logic [LEN_WIDTH-1:0]      ddr_rd_len,
  input  logic [DATA_WIDTH-1:0]     ddr_rd_data,
  input  logic                      ddr_rd_data_valid,
  input  logic                      ddr_rd_finish,
  output logic [1:0]                grant,
  output logic                      busy,
  output logic                      err
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BURST);

  arb_state_t                state_q, state_d;
  logic [1:0]                pick;
  logic [1:0]                grant_q;
  logic [DDR_ADDR_WIDTH-1:0] addr_q, sel_addr;
  logic [LEN_WIDTH-1:0]      len_q, sel_len;
  logic [LEN_WIDTH-1:0]      isa_cnt_q, dat_cnt_q, cur_cnt, cnt_next;
  logic [ISA_WIDTH-1:0]      isa_data_q;
  logic [DATA_WIDTH-1:0]     dat_data_q;
  logic                      isa_valid_q, dat_valid_q, err_q;
  logic                      beat_ok;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst        (rst),
    .req        ({dat_rd_req, isa_rd_req}),
    .update     (state_q == ST_DONE),
    .served_isa (grant_q[GNT_ISA]),
    .pick       (pick)
  );

  assign sel_addr = pick[GNT_DAT] ? dat_rd_addr : isa_rd_addr;
  assign sel_len  = clamp_len(pick[GNT_DAT] ? dat_rd_len : isa_rd_len, MAX_LEN);

  // Beats past the latched length are dropped; the count never exceeds len.
  assign cur_cnt  = grant_q[GNT_DAT] ? dat_cnt_q : isa_cnt_q;
  assign beat_ok  = ddr_rd_data_valid && (cur_cnt < len_q);
  assign cnt_next = cur_cnt + LEN_WIDTH'(beat_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|pick) state_d = (sel_len == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: state_d = ST_XFER;
      ST_XFER:  if (ddr_rd_finish) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q     <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      isa_cnt_q   <= '0;
      dat_cnt_q   <= '0;
      isa_data_q  <= '0;
      dat_data_q  <= '0;
      isa_valid_q <= 1'b0;
      dat_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      isa_valid_q <= 1'b0;
      dat_valid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|pick) begin
            grant_q <= pick;
            addr_q  <= sel_addr;
            len_q   <= sel_len;
            if (pick[GNT_ISA]) isa_cnt_q <= '0;
            else               dat_cnt_q <= '0;
          end
        end
        ST_XFER: begin
          if (beat_ok) begin
            if (grant_q[GNT_ISA]) begin
              isa_data_q  <= ddr_rd_data[ISA_WIDTH-1:0];
              isa_valid_q <= 1'b1;
              isa_cnt_q   <= cnt_next;
            end else begin
              dat_data_q  <= ddr_rd_data;
              dat_valid_q <= 1'b1;
              dat_cnt_q   <= cnt_next;
            end
          end
          // cnt_next already includes a beat arriving with finish.
          if ((ddr_rd_data_valid && !beat_ok) || (ddr_rd_finish && (cnt_next < len_q)))
            err_q <= 1'b1;
        end
        ST_DONE: grant_q <= '0;
        default: ;
      endcase
    end
  end

  assign grant        = grant_q;
  assign busy         = (state_q != ST_IDLE);
  assign ddr_rd_req   = (state_q == ST_ISSUE) || (state_q == ST_XFER);
  assign ddr_rd_addr  = addr_q;
  assign ddr_rd_len   = len_q;
  assign isa_rd_data  = isa_data_q;
  assign isa_rd_valid = isa_valid_q;
  assign isa_rd_cnt   = isa_cnt_q;
  assign isa_rd_done  = (state_q == ST_DONE) && grant_q[GNT_ISA];
  assign dat_rd_data  = dat_data_q;
  assign dat_rd_valid = dat_valid_q;
  assign dat_rd_cnt   = dat_cnt_q;
  assign dat_rd_done  = (state_q == ST_DONE) && grant_q[GNT_DAT];
  assign err          = err_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed bench for ddr_rd_arbiter: inputs change and outputs are sampled on the
// falling edge, so every check sees the state left by the preceding rising edge.
module tb_ddr_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        isa_rd_req = 1'b0, dat_rd_req = 1'b0;
  logic [27:0] isa_rd_addr = '0, dat_rd_addr = '0;
  logic [9:0]  isa_rd_len = '0, dat_rd_len = '0;
  logic [29:0] isa_rd_data;
  logic [63:0] dat_rd_data;
  logic        isa_rd_valid, isa_rd_done, dat_rd_valid, dat_rd_done;
  logic [9:0]  isa_rd_cnt, dat_rd_cnt;
  logic        ddr_rd_req;
  logic [27:0] ddr_rd_addr;
  logic [9:0]  ddr_rd_len;
  logic [63:0] ddr_rd_data = '0;
  logic        ddr_rd_data_valid = 1'b0, ddr_rd_finish = 1'b0;
  logic [1:0]  grant;
  logic        busy, err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ddr_rd_arbiter #(.DDR_ADDR_WIDTH(28), .DATA_WIDTH(64), .ISA_WIDTH(30), .MAX_BURST(128)) dut (
    .clk(clk), .rst(rst),
    .isa_rd_req(isa_rd_req), .isa_rd_addr(isa_rd_addr), .isa_rd_len(isa_rd_len),
    .isa_rd_data(isa_rd_data), .isa_rd_valid(isa_rd_valid), .isa_rd_cnt(isa_rd_cnt), .isa_rd_done(isa_rd_done),
    .dat_rd_req(dat_rd_req), .dat_rd_addr(dat_rd_addr), .dat_rd_len(dat_rd_len),
    .dat_rd_data(dat_rd_data), .dat_rd_valid(dat_rd_valid), .dat_rd_cnt(dat_rd_cnt), .dat_rd_done(dat_rd_done),
    .ddr_rd_req(ddr_rd_req), .ddr_rd_addr(ddr_rd_addr), .ddr_rd_len(ddr_rd_len),
    .ddr_rd_data(ddr_rd_data), .ddr_rd_data_valid(ddr_rd_data_valid), .ddr_rd_finish(ddr_rd_finish),
    .grant(grant), .busy(busy), .err(err)
  );

  // Beat i carries 0xDEAD0000+i in the upper word and 0xF0000000+i in the lower word,
  // so the ISA side must see 0x30000000+i after truncation to 30 bits.
  function automatic logic [63:0] beat_val(input int i);
    return {32'hDEAD_0000 + 32'(i), 32'hF000_0000 + 32'(i)};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick();
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rst_grant: got %b want 00", grant); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (ddr_rd_req !== 1'b0) begin miscompares++; $display("FAIL rst_ddr_req: got %b want 0", ddr_rd_req); end
    vectors++; if (ddr_rd_len !== 10'd0) begin miscompares++; $display("FAIL rst_ddr_len: got %0d want 0", ddr_rd_len); end
    vectors++; if ({isa_rd_valid, dat_rd_valid, isa_rd_done, dat_rd_done, err} !== 5'b0) begin miscompares++; $display("FAIL rst_strobes: got %b want 00000", {isa_rd_valid, dat_rd_valid, isa_rd_done, dat_rd_done, err}); end
    vectors++; if ({isa_rd_cnt, dat_rd_cnt} !== 20'd0) begin miscompares++; $display("FAIL rst_cnts: got %0d/%0d want 0/0", isa_rd_cnt, dat_rd_cnt); end
    rst = 1'b1;
    tick();
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rst_idle_grant: got %b want 00", grant); end
  endtask

  task automatic test_both_first();
    isa_rd_req = 1'b1; isa_rd_addr = 28'h100; isa_rd_len = 10'd2;
    dat_rd_req = 1'b1; dat_rd_addr = 28'h200; dat_rd_len = 10'd3;
    tick();
    vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL rr1_grant: got %b want 01", grant); end
    vectors++; if (ddr_rd_addr !== 28'h100) begin miscompares++; $display("FAIL rr1_addr: got %h want 100", ddr_rd_addr); end
    vectors++; if (ddr_rd_req !== 1'b1) begin miscompares++; $display("FAIL rr1_ddr_req: got %b want 1", ddr_rd_req); end
    isa_rd_req = 1'b0;
    tick();
    for (int i = 1; i <= 2; i++) begin
      ddr_rd_data_valid = 1'b1; ddr_rd_data = beat_val(i);
      tick();
      vectors++; if (isa_rd_cnt !== 10'(i)) begin miscompares++; $display("FAIL rr1_isa_cnt: got %0d want %0d", isa_rd_cnt, i); end
    end
    ddr_rd_data_valid = 1'b0; ddr_rd_finish = 1'b1;
    tick();
    vectors++; if (isa_rd_done !== 1'b1) begin miscompares++; $display("FAIL rr1_isa_done: got %b want 1", isa_rd_done); end
    ddr_rd_finish = 1'b0;
    tick();
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rr1_gap_grant: got %b want 00", grant); end
    tick();
    vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL rr1_dat_grant: got %b want 10", grant); end
    vectors++; if (ddr_rd_addr !== 28'h200) begin miscompares++; $display("FAIL rr1_dat_addr: got %h want 200", ddr_rd_addr); end
    vectors++; if (ddr_rd_len !== 10'd3) begin miscompares++; $display("FAIL rr1_dat_len: got %0d want 3", ddr_rd_len); end
    dat_rd_req = 1'b0;
    tick();
    for (int i = 1; i <= 3; i++) begin
      ddr_rd_data_valid = 1'b1; ddr_rd_data = beat_val(10 + i);
      tick();
      vectors++; if (dat_rd_valid !== 1'b1) begin miscompares++; $display("FAIL rr1_dat_valid: got %b want 1", dat_rd_valid); end
      vectors++; if (dat_rd_data !== beat_val(10 + i)) begin miscompares++; $display("FAIL rr1_dat_data: got %h want %h", dat_rd_data, beat_val(10 + i)); end
      vectors++; if (dat_rd_cnt !== 10'(i)) begin miscompares++; $display("FAIL rr1_dat_cnt: got %0d want %0d", dat_rd_cnt, i); end
      vectors++; if (isa_rd_valid !== 1'b0 || isa_rd_cnt !== 10'd2) begin miscompares++; $display("FAIL rr1_isa_quiet: got valid %b cnt %0d want 0/2", isa_rd_valid, isa_rd_cnt); end
    end
    ddr_rd_data_valid = 1'b0; ddr_rd_finish = 1'b1;
    tick();
    vectors++; if ({dat_rd_done, isa_rd_done, err} !== 3'b100) begin miscompares++; $display("FAIL rr1_dat_done: got %b want 100", {dat_rd_done, isa_rd_done, err}); end
    ddr_rd_finish = 1'b0;
    tick();
  endtask

  task automatic test_zero_len();
    isa_rd_req = 1'b1; isa_rd_addr = 28'h300; isa_rd_len = 10'd0;
    tick();
    vectors++; if (isa_rd_done !== 1'b1) begin miscompares++; $display("FAIL z_done: got %b want 1", isa_rd_done); end
    vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL z_grant: got %b want 01", grant); end
    vectors++; if (ddr_rd_req !== 1'b0) begin miscompares++; $display("FAIL z_ddr_req: got %b want 0", ddr_rd_req); end
    vectors++; if (isa_rd_cnt !== 10'd0 || dat_rd_cnt !== 10'd3) begin miscompares++; $display("FAIL z_cnts: got %0d/%0d want 0/3", isa_rd_cnt, dat_rd_cnt); end
    isa_rd_req = 1'b0;
    tick();
    vectors++; if ({isa_rd_done, ddr_rd_req, grant} !== 4'b0000) begin miscompares++; $display("FAIL z_after: got %b want 0000", {isa_rd_done, ddr_rd_req, grant}); end
  endtask

  task automatic test_both_second();
    isa_rd_req = 1'b1; isa_rd_addr = 28'h400; isa_rd_len = 10'd5;
    dat_rd_req = 1'b1; dat_rd_addr = 28'h500; dat_rd_len = 10'd300;
    tick();
    vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL rr2_grant: got %b want 10", grant); end
    vectors++; if (ddr_rd_len !== 10'd128) begin miscompares++; $display("FAIL clamp_len: got %0d want 128", ddr_rd_len); end
    vectors++; if (ddr_rd_addr !== 28'h500) begin miscompares++; $display("FAIL rr2_addr: got %h want 500", ddr_rd_addr); end
    isa_rd_req = 1'b0; dat_rd_req = 1'b0;
    tick();
    for (int i = 1; i <= 128; i++) begin
      ddr_rd_data_valid = 1'b1; ddr_rd_data = beat_val(i);
      ddr_rd_finish = (i == 128);
      tick();
      vectors++; if (dat_rd_cnt !== 10'(i) || err !== 1'b0) begin miscompares++; $display("FAIL clamp_beat: got cnt %0d err %b want %0d/0", dat_rd_cnt, err, i); end
    end
    vectors++; if ({dat_rd_valid, dat_rd_done} !== 2'b11) begin miscompares++; $display("FAIL clamp_last_done: got %b want 11", {dat_rd_valid, dat_rd_done}); end
    ddr_rd_data_valid = 1'b0; ddr_rd_finish = 1'b0;
    tick();
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL clamp_end_grant: got %b want 00", grant); end
  endtask

  task automatic test_isa_only();
    isa_rd_req = 1'b1; isa_rd_addr = 28'h40; isa_rd_len = 10'd8;
    tick();
    vectors++; if (grant !== 2'b01 || ddr_rd_addr !== 28'h40 || ddr_rd_len !== 10'd8) begin miscompares++; $display("FAIL isa_issue: got g %b a %h l %0d want 01/40/8", grant, ddr_rd_addr, ddr_rd_len); end
    vectors++; if (isa_rd_cnt !== 10'd0) begin miscompares++; $display("FAIL isa_cnt_clr: got %0d want 0", isa_rd_cnt); end
    isa_rd_req = 1'b0;
    tick();
    vectors++; if (ddr_rd_req !== 1'b1) begin miscompares++; $display("FAIL isa_xfer_req: got %b want 1", ddr_rd_req); end
    for (int i = 1; i <= 8; i++) begin
      ddr_rd_data_valid = 1'b1; ddr_rd_data = beat_val(i);
      tick();
      vectors++; if (isa_rd_valid !== 1'b1) begin miscompares++; $display("FAIL isa_valid: got %b want 1", isa_rd_valid); end
      vectors++; if (isa_rd_data !== 30'h3000_0000 + 30'(i)) begin miscompares++; $display("FAIL isa_data: got %h want %h", isa_rd_data, 30'h3000_0000 + 30'(i)); end
      vectors++; if (isa_rd_cnt !== 10'(i)) begin miscompares++; $display("FAIL isa_cnt: got %0d want %0d", isa_rd_cnt, i); end
      vectors++; if ({dat_rd_valid, err} !== 2'b00) begin miscompares++; $display("FAIL isa_dat_silent: got %b want 00", {dat_rd_valid, err}); end
    end
    ddr_rd_data_valid = 1'b0; ddr_rd_finish = 1'b1;
    tick();
    vectors++; if ({isa_rd_done, dat_rd_done, err, ddr_rd_req} !== 4'b1000) begin miscompares++; $display("FAIL isa_done: got %b want 1000", {isa_rd_done, dat_rd_done, err, ddr_rd_req}); end
    ddr_rd_finish = 1'b0;
    tick();
    vectors++; if ({isa_rd_done, grant, busy} !== 4'b0000) begin miscompares++; $display("FAIL isa_idle: got %b want 0000", {isa_rd_done, grant, busy}); end
  endtask

  task automatic test_short();
    isa_rd_req = 1'b1; isa_rd_addr = 28'h80; isa_rd_len = 10'd4;
    tick();
    isa_rd_req = 1'b0;
    tick();
    for (int i = 1; i <= 3; i++) begin
      ddr_rd_data_valid = 1'b1; ddr_rd_data = beat_val(20 + i);
      tick();
    end
    ddr_rd_data_valid = 1'b0; ddr_rd_finish = 1'b1;
    tick();
    vectors++; if ({isa_rd_done, err} !== 2'b11) begin miscompares++; $display("FAIL short_err: got done/err %b want 11", {isa_rd_done, err}); end
    vectors++; if (isa_rd_cnt !== 10'd3) begin miscompares++; $display("FAIL short_cnt: got %0d want 3", isa_rd_cnt); end
    ddr_rd_finish = 1'b0;
    tick();
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL short_err_pulse: got %b want 0", err); end
  endtask

  task automatic test_overflow();
    dat_rd_req = 1'b1; dat_rd_addr = 28'h600; dat_rd_len = 10'd4;
    tick();
    dat_rd_req = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      ddr_rd_data_valid = 1'b1; ddr_rd_data = beat_val(30 + i);
      tick();
      vectors++; if (dat_rd_valid !== (i <= 4) || err !== (i == 5)) begin miscompares++; $display("FAIL ovf_beat%0d: got valid %b err %b want %b/%b", i, dat_rd_valid, err, (i <= 4), (i == 5)); end
    end
    vectors++; if (dat_rd_cnt !== 10'd4 || dat_rd_data !== beat_val(34)) begin miscompares++; $display("FAIL ovf_hold: got cnt %0d data %h want 4/%h", dat_rd_cnt, dat_rd_data, beat_val(34)); end
    ddr_rd_data_valid = 1'b0; ddr_rd_finish = 1'b1;
    tick();
    vectors++; if ({dat_rd_done, err} !== 2'b10) begin miscompares++; $display("FAIL ovf_done: got %b want 10", {dat_rd_done, err}); end
    ddr_rd_finish = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    isa_rd_req = 1'b1; isa_rd_addr = 28'hC0; isa_rd_len = 10'd4;
    tick();
    isa_rd_req = 1'b0;
    tick();
    for (int i = 1; i <= 2; i++) begin
      ddr_rd_data_valid = 1'b1; ddr_rd_data = beat_val(40 + i);
      tick();
    end
    rst = 1'b0;
    #1;
    vectors++; if ({grant, busy, ddr_rd_req, isa_rd_valid, err} !== 6'b0) begin miscompares++; $display("FAIL mid_rst_ctl: got %b want 000000", {grant, busy, ddr_rd_req, isa_rd_valid, err}); end
    vectors++; if (isa_rd_cnt !== 10'd0 || ddr_rd_len !== 10'd0 || ddr_rd_addr !== 28'h0 || isa_rd_data !== 30'h0) begin miscompares++; $display("FAIL mid_rst_data: got cnt %0d len %0d addr %h data %h want all 0", isa_rd_cnt, ddr_rd_len, ddr_rd_addr, isa_rd_data); end
    ddr_rd_data_valid = 1'b0;
    tick();
    rst = 1'b1;
    isa_rd_req = 1'b1; isa_rd_addr = 28'hD0; isa_rd_len = 10'd4;
    tick();
    vectors++; if (grant !== 2'b01 || ddr_rd_addr !== 28'hD0) begin miscompares++; $display("FAIL post_rst_grant: got %b %h want 01/d0", grant, ddr_rd_addr); end
    isa_rd_req = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      ddr_rd_data_valid = 1'b1; ddr_rd_data = beat_val(50 + i);
      ddr_rd_finish = (i == 4);
      tick();
    end
    vectors++; if ({isa_rd_done, err} !== 2'b10 || isa_rd_cnt !== 10'd4) begin miscompares++; $display("FAIL post_rst_done: got done/err %b cnt %0d want 10/4", {isa_rd_done, err}, isa_rd_cnt); end
    vectors++; if (isa_rd_data !== 30'h3000_0000 + 30'd54) begin miscompares++; $display("FAIL post_rst_data: got %h want %h", isa_rd_data, 30'h3000_0000 + 30'd54); end
    ddr_rd_data_valid = 1'b0; ddr_rd_finish = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_both_first();
    test_zero_len();
    test_both_second();
    test_isa_only();
    test_short();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
